out_port_ctrl: RTL and testbench
================================

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
- REQ-001: Parameter DEPTH, default 4: number of buffered output words; power of two, >= 2.
- REQ-002: Parameter CW, default 3: width of out_count; equals log2(DEPTH)+1.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: bus  input  16  CPU data bus; value captured on an accepted write.
- REQ-006: out_write  input  1  control-unit strobe; request to push bus into the output buffer this cycle.
- REQ-007: out_ready  input  1  external consumer (display/host) ready to take out_data.
- REQ-008: out_data  output  16  head-of-buffer word; 16'h0000 when empty.
- REQ-009: out_valid  output  1  out_data holds a valid word.
- REQ-010: out_full  output  1  buffer holds DEPTH words; control unit stalls on it.
- REQ-011: out_count  output  CW  number of words currently buffered, 0..DEPTH.
- REQ-012: ovf_err  output  1  sticky flag; a write was dropped because the buffer was full.

Function
- REQ-013: The block SHALL implement a DEPTH-entry FIFO of 16-bit words with wr_ptr and rd_ptr that wrap modulo DEPTH.
- REQ-014: The block SHALL maintain a 3-state FSM: EMPTY (count 0), ACTIVE (0 < count < DEPTH), FULL (count == DEPTH). Each transition occurs on the clock edge after the event.
- REQ-015: Write accept: out_write=1 and state != FULL at the edge; bus stored at wr_ptr; wr_ptr+1; count+1.
- REQ-016: Read accept: out_valid=1 and out_ready=1 at the edge; rd_ptr+1; count-1.
- REQ-017: Both accepted in the same cycle: count unchanged, both pointers advance, state unchanged.
- REQ-018: Write while FULL SHALL be dropped, even if a read is accepted that same cycle. The FULL evaluation uses pre-edge state. ovf_err is set to 1 on the next edge.
- REQ-019: ovf_err SHALL remain 1 until rst; no other clear path.
- REQ-020: No bypass: a word written into an EMPTY buffer appears on out_data with out_valid=1 one cycle after the write edge (latency 1).
- REQ-021: out_valid=1 iff state != EMPTY; out_full=1 iff state == FULL. Both are registered/FSM-derived and glitch-free.
- REQ-022: out_data SHALL equal mem[rd_ptr] when out_valid=1, else 16'h0000. It is stable while out_valid=1 and out_ready=0.
- REQ-023: out_ready with out_valid=0 SHALL have no effect; count never underflows below 0.
- REQ-024: Transitions:
  - EMPTY->ACTIVE on a write.
  - ACTIVE->FULL on a write-only cycle at count DEPTH-1.
  - ACTIVE->EMPTY on a read-only cycle at count 1.
  - FULL->ACTIVE on a read-only cycle.
  - All other combinations hold state.
- REQ-025: Stored data SHALL be delivered in write order with no duplication or loss, apart from REQ-018 drops.

Reset
- REQ-026: On rst=1 at a clock edge:
  - state=EMPTY; wr_ptr=rd_ptr=0; out_count=0.
  - out_valid=0, out_full=0, ovf_err=0, out_data=16'h0000.
- REQ-027: rst SHALL take priority over a simultaneous out_write or read. Buffered words are discarded mid-operation; memory contents need not be cleared.
- REQ-028: Outputs SHALL be undefined-free from the first edge with rst=1; no asynchronous reset path exists.

Verification
- REQ-029: Write 16'h1234 with out_ready=0 -> next cycle out_valid=1, out_data=16'h1234, out_count=1; holds until out_ready=1, then EMPTY, out_data=16'h0000.
- REQ-030: Write 16'hA000..16'hA003 back-to-back, out_ready=0 -> out_full=1, out_count=4; then a fifth write 16'hBEEF -> dropped, ovf_err=1. Draining yields A000,A001,A002,A003 only.
- REQ-031: FULL, then out_write=1 and out_ready=1 in the same cycle -> A000 read; write dropped; out_count=3; ovf_err=1.
- REQ-032: ACTIVE at count 2, simultaneous write 16'h5555 and read -> out_count stays 2; order preserved. Run a 20-word continuous stream with out_ready=1 to exercise pointer wrap; all words arrive in order.
- REQ-033: Three words buffered, rst=1 with out_write=1 in the same cycle -> next cycle out_count=0, out_valid=0, ovf_err=0; the write is not stored.
- REQ-034: Read attempts while EMPTY (out_ready=1, no writes for 5 cycles) -> out_count stays 0, out_valid stays 0, no pointer movement.

Source files
------------

// File: rtl/out_port_ctrl.sv
// Output port buffer: a small FIFO between the CPU data bus and an external consumer,
// with a registered EMPTY/ACTIVE/FULL state machine and a sticky overflow flag.
module out_port_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   bus,
  input  logic          out_write,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          out_valid,
  output logic          out_full,
  output logic [CW-1:0] out_count,
  output logic          ovf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  logic [15:0]   mem [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wrAcc, rdAcc;

  // Acceptance is judged on pre-edge state, so a write while FULL is dropped
  // even when a read frees a slot in the same cycle.
  assign wrAcc = out_write && (state_q != FULL);
  assign rdAcc = out_ready && (state_q != EMPTY);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    state_d = state_q;
    ovf_d   = ovf_q | (out_write && (state_q == FULL));
    if (wrAcc) wrPtr_d = wrPtr_q + AW'(1);
    if (rdAcc) rdPtr_d = rdPtr_q + AW'(1);
    if (wrAcc && !rdAcc) count_d = count_q + CW'(1);
    else if (rdAcc && !wrAcc) count_d = count_q - CW'(1);
    if (count_d == '0) state_d = EMPTY;
    else if (count_d == CW'(DEPTH)) state_d = FULL;
    else state_d = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is intentionally not cleared by reset; out_data masks stale words.
  always_ff @(posedge clk) begin
    if (!rst && wrAcc) mem[wrPtr_q] <= bus;
  end

  assign out_valid = (state_q != EMPTY);
  assign out_full  = (state_q == FULL);
  assign out_count = count_q;
  assign ovf_err   = ovf_q;
  assign out_data  = out_valid ? mem[rdPtr_q] : 16'h0000;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: stimulus queues expected words, a negedge
// monitor pops and compares each word the consumer accepts.
module tb_out_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus;
  logic        out_write;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_full;
  logic [2:0]  out_count;
  logic        ovf_err;

  logic [15:0] expQ[$];
  int          vecCount = 0;
  int          errCount = 0;

  out_port_ctrl #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .out_write(out_write), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_full(out_full),
    .out_count(out_count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; expectStore queues the word the consumer should later see.
  task automatic applyStimulus(input logic wr, input logic [15:0] data, input logic rdy,
                               input logic expectStore);
    out_write = wr;
    bus       = data;
    out_ready = rdy;
    if (expectStore) expQ.push_back(data);
    tick();
    out_write = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    checkOutput({name, "_drained"}, {15'd0, out_valid}, 16'h0);
    checkOutput({name, "_cnt0"}, {13'd0, out_count}, 16'h0);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        vecCount++;
        errCount++;
        $display("[TB] FAIL sbUnexpected: got %h expected no word", out_data);
      end else begin
        checkOutput("sbData", out_data, expQ.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; bus = '0; out_write = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rstCount", {13'd0, out_count}, 16'h0);
    checkOutput("rstValid", {15'd0, out_valid}, 16'h0);
    checkOutput("rstFull",  {15'd0, out_full},  16'h0);
    checkOutput("rstOvf",   {15'd0, ovf_err},   16'h0);
    checkOutput("rstData",  out_data,           16'h0000);

    // Single word, held until the consumer is ready.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
    checkOutput("oneValid", {15'd0, out_valid}, 16'h1);
    checkOutput("oneData",  out_data,           16'h1234);
    checkOutput("oneCount", {13'd0, out_count}, 16'h1);
    tick(); tick();
    checkOutput("oneHold",  out_data,           16'h1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("oneEmpty", {15'd0, out_valid}, 16'h0);
    checkOutput("oneZero",  out_data,           16'h0000);

    // Fill, then overflow.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b1);
    checkOutput("fullFlag",  {15'd0, out_full},  16'h1);
    checkOutput("fullCount", {13'd0, out_count}, 16'h4);
    checkOutput("fullNoOvf", {15'd0, ovf_err},   16'h0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    checkOutput("ovfSet",    {15'd0, ovf_err},   16'h1);
    checkOutput("ovfCount",  {13'd0, out_count}, 16'h4);

    // Write and read together while FULL: read proceeds, write dropped.
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    out_ready = 1'b0;
    checkOutput("fullRwCount", {13'd0, out_count}, 16'h3);
    checkOutput("fullRwFull",  {15'd0, out_full},  16'h0);
    checkOutput("fullRwOvf",   {15'd0, ovf_err},   16'h1);
    drain("fullDrain");
    checkOutput("ovfSticky", {15'd0, ovf_err}, 16'h1);

    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("ovfCleared", {15'd0, ovf_err}, 16'h0);

    // Simultaneous read/write at count 2, then a wrapping stream.
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1);
    out_ready = 1'b0;
    checkOutput("rwCount", {13'd0, out_count}, 16'h2);
    checkOutput("rwHead",  out_data,           16'h0002);
    drain("rwDrain");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'hC100 + 16'(i), 1'b1, 1'b1);
    checkOutput("streamCount", {13'd0, out_count}, 16'h1);
    drain("streamDrain");

    // Reset beats a simultaneous write.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0);
    checkOutput("preRstCount", {13'd0, out_count}, 16'h3);
    rst = 1'b1; out_write = 1'b1; bus = 16'hDEAD;
    tick();
    rst = 1'b0; out_write = 1'b0;
    checkOutput("rstWrCount", {13'd0, out_count}, 16'h0);
    checkOutput("rstWrValid", {15'd0, out_valid}, 16'h0);
    checkOutput("rstWrOvf",   {15'd0, ovf_err},   16'h0);
    tick();
    checkOutput("rstWrNotStored", {15'd0, out_valid}, 16'h0);

    // Reads while EMPTY must not move anything.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("emptyRdCount", {13'd0, out_count}, 16'h0);
      checkOutput("emptyRdValid", {15'd0, out_valid}, 16'h0);
    end
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'hC0DE, 1'b0, 1'b1);
    checkOutput("ptrIntact", out_data, 16'hC0DE);
    drain("finalDrain");

    checkOutput("sbEmpty", 16'(expQ.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
